// File: rtl/bsg_serial_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_serial_cfg_pkg
//  Description : Shared types, op encodings and the op/param decode helper
//                for the serial configuration client.
//  Revision    : 1.0 - initial release
// ============================================================================
package bsg_serial_cfg_pkg;

    // One beat of the 2-wire serial configuration bus
    typedef struct packed {
        logic op;
        logic param;
    } bsg_serial_cfg_s;

    // Decoded meaning of one registered bus beat
    typedef struct packed {
        logic shift;
        logic rst_op;
        logic nop;
    } bsg_serial_cfg_dec_s;

    // op=1 is a shift regardless of param; op=0 splits on param
    localparam logic            c_OP_SHIFT = 1'b1;
    localparam bsg_serial_cfg_s c_OP_RESET = '{op: 1'b0, param: 1'b1};
    localparam bsg_serial_cfg_s c_OP_NOP   = '{op: 1'b0, param: 1'b0};

    function automatic bsg_serial_cfg_dec_s bsg_serial_cfg_decode(input bsg_serial_cfg_s beat);
        bsg_serial_cfg_dec_s dec;
        dec.shift  = (beat.op == c_OP_SHIFT);
        dec.rst_op = (beat == c_OP_RESET);
        dec.nop    = (beat == c_OP_NOP);
        return dec;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_serial_cfg_sync.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_serial_cfg_sync
//  Description : Toggle-launch flop followed by a 2-flop synchronizer. Each
//                send pulse flips the toggle once; clear_i zeroes the chain.
//  Revision    : 1.0 - initial release
// ============================================================================
module bsg_serial_cfg_sync (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic send_i,
    input  logic clear_i,
    output logic sync_o
);

    logic tog_q,   tog_d;
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    // Next-state: toggle on send, shift toggle through the sync pair; clear wins
    always_comb begin
        tog_d   = tog_q ^ send_i;
        sync1_d = tog_q;
        sync2_d = sync1_q;
        if (clear_i) begin
            tog_d   = 1'b0;
            sync1_d = 1'b0;
            sync2_d = 1'b0;
        end
    end

    // Toggle and synchronizer flops
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tog_q   <= 1'b0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            tog_q   <= tog_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign sync_o = sync2_q;

endmodule
`default_nettype wire

// File: rtl/bsg_serial_cfg_client.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_serial_cfg_client
//  Description : Leaf serial configuration client. Shifts a width_p-bit word
//                in LSB first, commits it through a toggle/synchronizer
//                pipeline into a held output register and pulses new_r_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module bsg_serial_cfg_client
    import bsg_serial_cfg_pkg::*;
#(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               op_i,
    input  logic               param_i,
    output logic               new_r_o,
    output logic [width_p-1:0] data_r_o
);

    bsg_serial_cfg_s     cfg_q, cfg_d;
    logic                op_r_r_q, op_r_r_d;
    logic [width_p-1:0]  sh_q, sh_d, sh_next;
    logic                rtog_q, rtog_d;
    logic                new_r_q, new_r_d;
    logic                new_r_r_q, new_r_r_d;
    logic [width_p-1:0]  data_q, data_d;

    bsg_serial_cfg_dec_s dec;
    logic                send;
    logic                sync2;
    logic                new_c;

    // Decode registered bus bits; send marks the single nop closing a shift run
    always_comb begin
        dec  = bsg_serial_cfg_decode(cfg_q);
        send = op_r_r_q & dec.nop;
    end

    bsg_serial_cfg_sync u_sync (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .send_i    (send),
        .clear_i   (dec.rst_op),
        .sync_o    (sync2)
    );

    // Shift-in value: new bit enters at the MSB so the first bit ends at the LSB
    generate
        if (width_p == 1) begin : g_sh_w1
            always_comb sh_next = cfg_q.param;
        end else begin : g_sh_wn
            always_comb sh_next = {cfg_q.param, sh_q[width_p-1:1]};
        end
    endgenerate

    // Next-state for input regs, shift reg, commit detect and output register
    always_comb begin
        cfg_d     = '{op: op_i, param: param_i};
        op_r_r_d  = cfg_q.op;
        sh_d      = dec.shift ? sh_next : sh_q;
        new_c     = rtog_q ^ sync2;
        rtog_d    = sync2;
        new_r_d   = new_c;
        new_r_r_d = new_r_q;
        data_d    = new_r_q ? sh_q : data_q;
        // rst_op flushes the commit pipeline but keeps sh and data
        if (dec.rst_op) begin
            rtog_d    = 1'b0;
            new_r_d   = 1'b0;
            new_r_r_d = 1'b0;
        end
    end

    // State flops, all cleared by the async reset
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cfg_q     <= '{op: 1'b0, param: 1'b0};
            op_r_r_q  <= 1'b0;
            sh_q      <= '0;
            rtog_q    <= 1'b0;
            new_r_q   <= 1'b0;
            new_r_r_q <= 1'b0;
            data_q    <= '0;
        end else begin
            cfg_q     <= cfg_d;
            op_r_r_q  <= op_r_r_d;
            sh_q      <= sh_d;
            rtog_q    <= rtog_d;
            new_r_q   <= new_r_d;
            new_r_r_q <= new_r_r_d;
            data_q    <= data_d;
        end
    end

    assign new_r_o  = new_r_r_q;
    assign data_r_o = data_q;

endmodule
`default_nettype wire

// File: tb/tb_bsg_serial_cfg_client.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bsg_serial_cfg_client
//  Description : Directed vector bench for bsg_serial_cfg_client (width 8
//                and width 1 instances).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bsg_serial_cfg_client;

    logic       clk;
    logic       reset_n;
    logic       op8, param8;
    logic       op1, param1;
    logic       new8, new1;
    logic [7:0] data8;
    logic [0:0] data1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       op;
        logic       prm;
        logic       exp_new;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl[$];

    bsg_serial_cfg_client #(.width_p(8)) u_dut_w8 (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .op_i      (op8),
        .param_i   (param8),
        .new_r_o   (new8),
        .data_r_o  (data8)
    );

    bsg_serial_cfg_client #(.width_p(1)) u_dut_w1 (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .op_i      (op1),
        .param_i   (param1),
        .new_r_o   (new1),
        .data_r_o  (data1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic op, input logic prm, input logic en, input logic [7:0] ed);
        vec_t v;
        v.op = op; v.prm = prm; v.exp_new = en; v.exp_data = ed;
        tbl.push_back(v);
    endtask

    task automatic add_bits(input logic [7:0] w, input logic [7:0] ed);
        for (int i = 0; i < 8; i++) add(1'b1, w[i], 1'b0, ed);
    endtask

    task automatic add_nops(input int n, input logic [7:0] ed);
        for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b0, ed);
    endtask

    // Drive both instances for one cycle, return just after the sampling edge
    task automatic cycle(input logic o8, input logic p8, input logic o1, input logic p1);
        @(negedge clk);
        op8 = o8; param8 = p8; op1 = o1; param1 = p1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        op8 = 1'b0; param8 = 1'b0; op1 = 1'b0; param1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_new8",  {7'd0, new8},  8'h00);
        check("reset_data8", data8,         8'h00);
        check("reset_new1",  {7'd0, new1},  8'h00);
        check("reset_data1", {7'd0, data1}, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;

        // Vector table: each entry is one cycle; expectations are after its sampling edge
        add(1'b0, 1'b1, 1'b0, 8'h00);          // rst_op
        add_bits(8'hA5, 8'h00);                // bits on edges 1..8
        add_nops(5, 8'h00);                    // edges 9..13
        add(1'b0, 1'b0, 1'b1, 8'hA5);          // edge 14 = w+6
        add_nops(1, 8'hA5);                    // pulse drops
        add_bits(8'h3C, 8'hA5);
        add_nops(5, 8'hA5);
        add(1'b0, 1'b0, 1'b1, 8'h3C);
        add_nops(1, 8'h3C);
        add_bits(8'hFF, 8'h3C);                // shift run ended by rst_op: no commit
        add(1'b0, 1'b1, 1'b0, 8'h3C);
        add_nops(7, 8'h3C);
        add_bits(8'h5A, 8'h3C);                // toggle flips at w+2 ...
        add_nops(2, 8'h3C);
        add(1'b0, 1'b1, 1'b0, 8'h3C);          // ... rst_op while it is high
        add_nops(9, 8'h3C);
        add(1'b1, 1'b1, 1'b0, 8'h3C);          // two junk bits
        add(1'b1, 1'b1, 1'b0, 8'h3C);
        add_bits(8'h12, 8'h3C);
        add_nops(5, 8'h3C);
        add(1'b0, 1'b0, 1'b1, 8'h12);
        add_nops(3, 8'h12);

        foreach (tbl[i]) begin
            cycle(tbl[i].op, tbl[i].prm, 1'b0, 1'b0);
            check($sformatf("vec%0d_new", i),  {7'd0, new8}, {7'd0, tbl[i].exp_new});
            check($sformatf("vec%0d_data", i), data8,        tbl[i].exp_data);
        end
        check("w1_idle_new",  {7'd0, new1},  8'h00);
        check("w1_idle_data", {7'd0, data1}, 8'h00);

        // Async reset in the middle of a shift run clears outputs without a clock edge
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_data8", data8,        8'h00);
        check("async_rst_new8",  {7'd0, new8}, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;

        // rst_op then word 0x81; pulse expected 6 edges after the last bit
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] w;
            w = 8'h81;
            cycle(1'b1, w[i], 1'b0, 1'b0);
        end
        n = 0;
        while (n < 20) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            n++;
            if (new8) break;
            check("post_rst_hold", data8, 8'h00);
        end
        check("post_rst_latency", n[7:0], 8'd6);
        check("post_rst_data",    data8,  8'h81);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("post_rst_pulse_end", {7'd0, new8}, 8'h00);

        // Width-1 instance: rst_op, one bit of 1, nop
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        check("w1_before", {7'd0, data1}, 8'h00);
        n = 0;
        while (n < 20) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            n++;
            if (new1) break;
        end
        check("w1_latency", n[7:0],        8'd6);
        check("w1_data",    {7'd0, data1}, 8'h01);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("w1_pulse_end", {7'd0, new1}, 8'h00);
        check("w8_unchanged", data8,        8'h81);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
